// File: rtl/calc_pkg.sv
// calc_pkg
//   Constants and helpers shared by the calculator front end.
//   SEL_*   : encodings of the 2-bit operand target select.
//   NIBBLES : number of buttons, one per hex nibble of the target word.
//   NIB_W   : width of one nibble.
//   nibStep : one-nibble increment/decrement with wrap-around.
package calc_pkg;

  localparam logic [1:0] SEL_NUM1_LO = 2'b00;
  localparam logic [1:0] SEL_NUM2    = 2'b01;
  localparam logic [1:0] SEL_NUM1_HI = 2'b10;
  localparam logic [1:0] SEL_NONE    = 2'b11;

  localparam int NIBBLES = 8;
  localparam int NIB_W   = 4;

  // Operand edit target decoded from the select lines
  typedef enum logic [1:0] {
    TGT_NUM1_LO = 2'b00,
    TGT_NUM2    = 2'b01,
    TGT_NUM1_HI = 2'b10,
    TGT_NONE    = 2'b11
  } target_e;

  // Steps a nibble by one. The result is only NIB_W bits wide, so 0xF+1
  // and 0x0-1 wrap inside the nibble and never reach a neighbour.
  function automatic logic [NIB_W-1:0] nibStep(input logic [NIB_W-1:0] nib,
                                               input logic             down);
    logic [NIB_W-1:0] res;
    if (down) begin
      res = nib - NIB_W'(1);
    end else begin
      res = nib + NIB_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Turns one raw, asynchronous push-button into a single-cycle press pulse.
//   The button passes through a 2-FF synchronizer, then a stability counter
//   decides when the accepted level may follow the synchronized level. A
//   rising edge of the accepted level gives a one-cycle press.
//
// Ports
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   key_in  in  raw button level
//   press   out one-cycle pulse in the cycle after the accepted level rises
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press
);

  // With DEBOUNCE_CYCLES == 1 the counter never advances, but it still needs
  // at least one bit to exist.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             keyMeta_q;
  logic             keySync_q;
  logic [CNT_W-1:0] stableCnt_q;
  logic [CNT_W-1:0] stableCnt_d;
  logic             dbLevel_q;
  logic             dbLevel_d;
  logic             dbPrev_q;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keyMeta_q <= 1'b0;
      keySync_q <= 1'b0;
    end else begin
      keyMeta_q <= key_in;
      keySync_q <= keyMeta_q;
    end
  end

  // The counter runs only while the synchronized level disagrees with the
  // accepted level. Once it has seen DEBOUNCE_CYCLES disagreeing cycles in a
  // row the new level is accepted; any agreement in between clears it, so
  // short glitches are dropped.
  always_comb begin
    stableCnt_d = stableCnt_q;
    dbLevel_d   = dbLevel_q;
    if (keySync_q == dbLevel_q) begin
      stableCnt_d = '0;
    end else if (stableCnt_q == CNT_LAST) begin
      dbLevel_d   = keySync_q;
      stableCnt_d = '0;
    end else begin
      stableCnt_d = stableCnt_q + CNT_W'(1);
    end
  end

  // Accepted level, its counter, and the delayed copy used for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stableCnt_q <= '0;
      dbLevel_q   <= 1'b0;
      dbPrev_q    <= 1'b0;
    end else begin
      stableCnt_q <= stableCnt_d;
      dbLevel_q   <= dbLevel_d;
      dbPrev_q    <= dbLevel_q;
    end
  end

  // Only the 0->1 transition is a press; releases are silent
  assign press = dbLevel_q & ~dbPrev_q;

endmodule

// File: rtl/operand_entry.sv
// operand_entry
//   Operand entry stage of the calculator. Eight debounced buttons each step
//   one hex nibble of the operand chosen by sel, up or down depending on the
//   direction switch. The operand registers feed the arithmetic and display
//   units directly.
//
// Ports
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   inc_in  in  raw buttons, bit i edits nibble i of the target word
//   dec     in  direction switch, 1 = decrement, 0 = increment
//   sel     in  target: 00 num1[31:0], 10 num1[63:32], 01 num2, 11 none
//   num1    out 64-bit operand 1
//   num2    out 32-bit operand 2
//   upd     out one-cycle pulse in the cycle after an operand nibble changed
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  inc_in,
  input  logic        dec,
  input  logic [1:0]  sel,
  output logic [63:0] num1,
  output logic [31:0] num2,
  output logic        upd
);

  logic [NIBBLES-1:0] press;
  logic               decMeta_q;
  logic               decSync_q;
  logic [63:0]        num1_q;
  logic [63:0]        num1_d;
  logic [31:0]        num2_q;
  logic [31:0]        num2_d;
  logic               upd_q;
  logic               upd_d;
  target_e            target;

  // One debouncer per button
  for (genvar g = 0; g < NIBBLES; g++) begin : gKey
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uKey (
      .clk    (clk),
      .rst    (rst),
      .key_in (inc_in[g]),
      .press  (press[g])
    );
  end

  // The direction switch is a slide switch, so it is only synchronized;
  // it is read solely in a press cycle, long after it has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decMeta_q <= 1'b0;
      decSync_q <= 1'b0;
    end else begin
      decMeta_q <= dec;
      decSync_q <= decMeta_q;
    end
  end

  assign target = target_e'(sel);

  // Every pressed button edits its own nibble of the selected word, so
  // simultaneous presses all land in the same cycle and share one upd.
  always_comb begin
    num1_d = num1_q;
    num2_d = num2_q;
    upd_d  = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (press[i]) begin
        unique case (target)
          TGT_NUM1_LO: begin
            num1_d[NIB_W*i +: NIB_W] = nibStep(num1_q[NIB_W*i +: NIB_W], decSync_q);
            upd_d = 1'b1;
          end
          TGT_NUM1_HI: begin
            num1_d[32 + NIB_W*i +: NIB_W] = nibStep(num1_q[32 + NIB_W*i +: NIB_W], decSync_q);
            upd_d = 1'b1;
          end
          TGT_NUM2: begin
            num2_d[NIB_W*i +: NIB_W] = nibStep(num2_q[NIB_W*i +: NIB_W], decSync_q);
            upd_d = 1'b1;
          end
          TGT_NONE: begin
            upd_d = 1'b0;
          end
          default: begin
            upd_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Operand registers and the update strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num1_q <= '0;
      num2_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      num1_q <= num1_d;
      num2_q <= num2_d;
      upd_q  <= upd_d;
    end
  end

  assign num1 = num1_q;
  assign num2 = num2_q;
  assign upd  = upd_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry
//   Bench for operand_entry with a short debounce window. A reference model
//   reasons on raw button samples (a level is accepted once it has been seen
//   D times in a row, and the edit appears three edges after that) and pushes
//   each expected operand update into a scoreboard that a monitor drains on
//   every upd pulse.
module tb_operand_entry;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  inc_in = '0;
  logic        dec = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [63:0] num1;
  logic [31:0] num2;
  logic        upd;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          edgeNo;
    logic [63:0] n1;
    logic [31:0] n2;
  } exp_t;

  exp_t sbQ[$];

  // Reference model state
  logic [63:0] m1;
  logic [31:0] m2;
  logic [7:0]  mAccepted;
  logic [7:0]  mLast;
  int          mRun[8];
  int          mPend[8];
  logic        decPrev1;
  logic        decPrev2;
  int          cycleNow = 0;

  operand_entry #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .inc_in (inc_in),
    .dec    (dec),
    .sel    (sel),
    .num1   (num1),
    .num2   (num2),
    .upd    (upd)
  );

  always #5 clk = ~clk;

  task automatic recordCheck(input string name, input logic ok,
                             input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] exp1,
                             input logic [31:0] exp2);
    recordCheck({name, "_num1"}, num1 === exp1, num1, exp1);
    recordCheck({name, "_num2"}, num2 === exp2, {32'h0, num2}, {32'h0, exp2});
  endtask

  // Drives the inputs just after a falling edge and holds them for n cycles
  task automatic applyStimulus(input logic [7:0] incVal, input logic decVal,
                               input logic [1:0] selVal, input int n);
    @(negedge clk);
    inc_in = incVal;
    dec    = decVal;
    sel    = selVal;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic pressOnce(input logic [7:0] mask, input logic decVal,
                           input logic [1:0] selVal);
    applyStimulus(mask, decVal, selVal, 8);
    applyStimulus(8'h00, decVal, selVal, 8);
  endtask

  // Reference model: each edge first applies edits that have matured, then
  // looks at the new raw sample to decide whether a button level has been
  // stable long enough to count as accepted.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m1 = '0;
        m2 = '0;
        mAccepted = '0;
        mLast = '0;
        decPrev1 = 1'b0;
        decPrev2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
          mRun[i]  = 0;
          mPend[i] = 0;
        end
        sbQ.delete();
      end else begin
        logic any;
        logic [3:0] nib;
        cycleNow++;
        any = 1'b0;
        for (int i = 0; i < 8; i++) begin
          if (mPend[i] > 0) begin
            mPend[i]--;
            if (mPend[i] == 0 && sel != 2'b11) begin
              any = 1'b1;
              case (sel)
                2'b00:   nib = m1[4*i +: 4];
                2'b10:   nib = m1[32 + 4*i +: 4];
                default: nib = m2[4*i +: 4];
              endcase
              nib = decPrev2 ? nib + 4'd15 : nib + 4'd1;
              case (sel)
                2'b00:   m1[4*i +: 4] = nib;
                2'b10:   m1[32 + 4*i +: 4] = nib;
                default: m2[4*i +: 4] = nib;
              endcase
            end
          end
        end
        if (any) sbQ.push_back('{cycleNow, m1, m2});
        for (int i = 0; i < 8; i++) begin
          if (inc_in[i] == mLast[i]) mRun[i]++;
          else mRun[i] = 1;
          mLast[i] = inc_in[i];
          if (mRun[i] >= D && inc_in[i] != mAccepted[i]) begin
            mAccepted[i] = inc_in[i];
            if (inc_in[i]) mPend[i] = 3;
          end
        end
        decPrev2 = decPrev1;
        decPrev1 = dec;
      end
    end
  end

  // Monitor: every upd must match the oldest expected update, on the right
  // cycle; the operands must track the model at all times.
  always @(negedge clk) begin
    if (!rst) begin
      if (sbQ.size() > 0 && sbQ[0].edgeNo < cycleNow) begin
        recordCheck("upd_missing", 1'b0, 64'(upd), 64'(sbQ[0].edgeNo));
        void'(sbQ.pop_front());
      end
      if (upd) begin
        if (sbQ.size() == 0) begin
          recordCheck("upd_spurious", 1'b0, 64'(upd), 64'h0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          recordCheck("upd_cycle", e.edgeNo == cycleNow, 64'(cycleNow), 64'(e.edgeNo));
          recordCheck("sb_num1", num1 === e.n1, num1, e.n1);
          recordCheck("sb_num2", num2 === e.n2, {32'h0, num2}, {32'h0, e.n2});
        end
      end
      recordCheck("track_num1", num1 === m1, num1, m1);
      recordCheck("track_num2", num2 === m2, {32'h0, num2}, {32'h0, m2});
    end
  end

  task automatic pulseReset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("reset_async", 64'h0, 32'h0);
    recordCheck("reset_upd", upd === 1'b0, 64'(upd), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] level;
    int         holdLeft[8];
    $display("[TB] operand_entry bench, DEBOUNCE_CYCLES=%0d", D);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Asynchronous reset in the middle of a cycle, then idle
    pulseReset();
    applyStimulus(8'h00, 1'b0, 2'b00, 10);
    checkOutput("idle_after_reset", 64'h0, 32'h0);

    // Single increment of num1 nibble 0
    applyStimulus(8'h01, 1'b0, 2'b00, 20);
    applyStimulus(8'h00, 1'b0, 2'b00, 12);
    checkOutput("single_inc", 64'h1, 32'h0);

    // Bounce on button 3: never stable for D cycles
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'h08, 1'b0, 2'b00, 3);
      applyStimulus(8'h00, 1'b0, 2'b00, 3);
    end
    applyStimulus(8'h00, 1'b0, 2'b00, 12);
    checkOutput("bounce", 64'h1, 32'h0);

    // num2 nibble 7 wraps down, then up twice with no spill
    applyStimulus(8'h00, 1'b1, 2'b01, 4);
    pressOnce(8'h80, 1'b1, 2'b01);
    checkOutput("wrap_down", 64'h1, 32'hF000_0000);
    applyStimulus(8'h00, 1'b0, 2'b01, 4);
    pressOnce(8'h80, 1'b0, 2'b01);
    pressOnce(8'h80, 1'b0, 2'b01);
    checkOutput("wrap_up", 64'h1, 32'h1000_0000);

    // Upper half of num1, two buttons on the same cycle; then sel = none
    pulseReset();
    pressOnce(8'h21, 1'b0, 2'b10);
    checkOutput("upper_simul", 64'h0010_0001_0000_0000, 32'h0);
    pressOnce(8'h21, 1'b0, 2'b11);
    checkOutput("sel_none", 64'h0010_0001_0000_0000, 32'h0);

    // Reset while button 2 is mid-debounce; the held button presses again
    pulseReset();
    @(negedge clk);
    inc_in = 8'h04;
    dec    = 1'b0;
    sel    = 2'b00;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(8'h00, 1'b0, 2'b00, 12);
    checkOutput("reset_mid_debounce", 64'h100, 32'h0);

    // Random buttons, direction and target
    level = '0;
    for (int i = 0; i < 8; i++) holdLeft[i] = $urandom_range(1, 9);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        holdLeft[i]--;
        if (holdLeft[i] <= 0) begin
          level[i]    = 1'($urandom_range(0, 1));
          holdLeft[i] = $urandom_range(1, 9);
        end
      end
      inc_in = level;
      if ($urandom_range(0, 9) == 0) dec = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) sel = 2'($urandom_range(0, 3));
    end
    applyStimulus(8'h00, dec, sel, 20);
    recordCheck("sb_drained", sbQ.size() == 0, 64'(sbQ.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
# operand_entry

Operand entry stage for the calculator top level: turns eight raw push-buttons, a direction switch and a 2-bit target select into edits of the two operand registers (64-bit `num1`, 32-bit `num2`). Each button steps one hex nibble of the selected operand. The block drives `num1`/`num2` directly into the ALU, divider, multiplier and display units. All state is clocked from the single system clock; the per-button asynchronous edges are replaced by synchronized, debounced, one-cycle press pulses.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button level is accepted; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `inc_in`  in  8  raw buttons; bit i edits nibble i of the target word.
- `dec`  in  1  direction switch: 1 = decrement, 0 = increment.
- `sel`  in  2  target: 00 = `num1[31:0]`, 10 = `num1[63:32]`, 01 = `num2`, 11 = none.
- `num1`  out  64  operand 1.
- `num2`  out  32  operand 2.
- `upd`  out  1  one-cycle pulse in the cycle after any nibble of `num1`/`num2` changed.

## Operation
- Each `inc_in[i]` and `dec` passes through a 2-FF synchronizer.
- Per button, a debouncer holds the accepted level `db` and a counter.
  - While the synchronized level equals `db`, the counter is held at 0.
  - While it differs, the counter increments each cycle.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the level still differs, `db` takes the new level and the counter clears.
  - A level mismatch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- A press is a 0→1 transition of `db`, detected against a registered copy of `db`, and gives a one-cycle `press[i]`. Releases produce nothing.
- On `press[i]`, the addressed nibble becomes nibble ± 1 mod 16. The direction is the synchronized `dec` in that cycle. Target nibble by `sel`:
  - 00: `num1[4i+3:4i]`
  - 10: `num1[32+4i+3:32+4i]`
  - 01: `num2[4i+3:4i]`
  - 11: no change and no `upd`
- Wrap-around: 0xF+1 → 0x0 and 0x0−1 → 0xF, with no carry or borrow into the neighbouring nibble.
- Simultaneous presses on different i all apply in the same cycle and produce a single `upd` pulse.
- `sel` and `dec` are sampled only in the press cycle. Changing them while a button is held does not re-trigger.
- Reset values: `num1`=0, `num2`=0, `upd`=0; all synchronizer, `db` and press registers 0; counters 0.
- Reset mid-debounce discards progress. A button still held when `rst` drops counts as a fresh press after the full latency.

## Timing
- Let E0 be the first clock edge that samples `inc_in[i]` high, with D = `DEBOUNCE_CYCLES`.
  - Synchronizer output is high after E1.
  - `db` rises at E(1+D).
  - `press[i]` is high in the cycle after E(1+D).
  - The nibble updates at E(2+D).
  - `upd` is high for exactly the cycle after E(2+D).
- Throughput: at most one step per button per full press/release cycle. A release needs D stable cycles before a new press can register.
- `num1`/`num2` are registered outputs and are stable between updates.

## Structure
- Shared package `calc_pkg`:
  - `SEL_NUM1_LO`=2'b00, `SEL_NUM2`=2'b01, `SEL_NUM1_HI`=2'b10, `SEL_NONE`=2'b11.
  - `NIBBLES`=8.
  - `NIB_W`=4.
- Sub-module `key_debounce` contains the synchronizer, counter, `db` and rise detect. It takes parameter `DEBOUNCE_CYCLES`, has ports `clk`, `rst`, `key_in`, `press`, and is instantiated 8×.
- `dec` uses a plain 2-FF synchronizer with no debounce.

## Test plan
All scenarios use D=4.
- Reset: assert `rst` asynchronously mid-cycle → `num1`=0, `num2`=0, `upd`=0 immediately; all stay 0 with buttons idle.
- Single increment: `sel`=00, `dec`=0, hold `inc_in[0]` 20 cycles → `num1`=0x...0001 updated exactly at E6; `upd` high one cycle; release with no further change.
- Bounce rejection: `inc_in[3]` toggles high 3 cycles/low 3 cycles ×5, then stays low → `num1`, `num2` unchanged, `upd` never asserted.
- Wrap and isolation: `sel`=01, `dec`=1, press `inc_in[7]` once → `num2`=0xF0000000. Then `dec`=0, press twice → `num2`=0x10000000 with no borrow or carry into the other bits.
- Upper half plus simultaneous presses: `sel`=10, `dec`=0, press `inc_in[0]` and `inc_in[5]` on the same cycle → `num1`=0x0010_0001_0000_0000 and a single `upd` pulse. Same stimulus with `sel`=11 → no change, no `upd`.
- Reset mid-debounce: hold `inc_in[2]`, pulse `rst` two cycles after E0, keep holding → exactly one increment of nibble 2, at edge 2+D after the first post-reset sampling edge.
